// File: rtl/hubris_mem_responder.sv
// hubris_mem_responder: responder for the core's data port (A) and fetch port (B).
// Dual-port word RAM with byte strobes and a 1-cycle registered read, plus a small
// MMIO window on port A feeding a TX byte FIFO drained by a ready/valid sink.
// Optional build macro: HUBRIS_MEM_IO_STATUS_EN enables the STATUS register and the
// sticky overflow flag; without it STATUS reads 0 and dropped bytes are silent.
module hubris_mem_responder #(
    parameter int          MEM_DEPTH_IN_WORD = 1024,
    parameter string       INIT_FILE         = "",
    parameter logic [31:0] IO_BASE           = 32'hFFFF_0000,
    parameter int          IO_FIFO_DEPTH     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en_a,
    input  logic [3:0]                       we_a,
    input  logic [31:0]                      addr_a,
    input  logic [31:0]                      din_a,
    output logic [31:0]                      dout_a,
    input  logic                             en_b,
    input  logic [3:0]                       we_b,
    input  logic [31:0]                      addr_b,
    input  logic [31:0]                      din_b,
    output logic [31:0]                      dout_b,
    output logic                             io_out_valid,
    output logic [7:0]                       io_out_data,
    input  logic                             io_out_ready,
    output logic [$clog2(IO_FIFO_DEPTH):0]   io_free_slots
);

    localparam int AW = $clog2(MEM_DEPTH_IN_WORD);
    localparam int PW = $clog2(IO_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(IO_FIFO_DEPTH);

    // ------------------------------------------------------------------ RAM
    logic [31:0]   mem [0:MEM_DEPTH_IN_WORD-1];
    logic [AW-1:0] word_a;
    logic [AW-1:0] word_b;

    // Word index only; byte offset and upper address bits alias.
    assign word_a = addr_a[AW+1:2];
    assign word_b = addr_b[AW+1:2];

    // MMIO decode: port A only; anything at or above IO_BASE never touches RAM.
    logic        io_sel_a;
    logic [31:0] io_off;
    logic        tx_sel;
    logic        status_sel;

    assign io_sel_a   = (addr_a >= IO_BASE);
    assign io_off     = addr_a - IO_BASE;
    assign tx_sel     = (io_off[31:2] == 30'd0);
    assign status_sel = (io_off[31:2] == 30'd1);

    // RAM byte writes: port B first, port A after, so A wins every byte it strobes.
    // NOTE: RAM is deliberately not reset; a reset loop over the array would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (en_b && we_b[i])
                mem[word_b][8*i +: 8] <= din_b[8*i +: 8];
            if (en_a && !io_sel_a && we_a[i])
                mem[word_a][8*i +: 8] <= din_a[8*i +: 8];
        end
    end

    // Port B registered read; read-first because the array update is non-blocking.
    // NOTE: non-blocking assignment here is what makes a same-edge write invisible to this read.
    always_ff @(posedge clk) begin
        if (reset)
            dout_b <= 32'd0;
        else if (en_b)
            dout_b <= mem[word_b];
    end

    // ----------------------------------------------------------------- FIFO
    logic [7:0]    fifo_mem [0:IO_FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_req;
    logic          push;
    logic          pop;

    assign push_req      = en_a && io_sel_a && tx_sel && we_a[0];
    assign pop           = io_out_valid && io_out_ready;
    // A pop on a full FIFO frees the slot in the same cycle, so the push is kept.
    assign push          = push_req && ((count != FIFO_FULL) || pop);
    assign io_out_valid  = (count != '0);
    assign io_out_data   = fifo_mem[rd_ptr];
    assign io_free_slots = FIFO_FULL - count;

    // FIFO storage write; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= din_a[7:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------- STATUS
    logic [31:0] status_word;

`ifdef HUBRIS_MEM_IO_STATUS_EN
    logic overflow;

    // Sticky overflow: set by a dropped push, cleared by a STATUS write with byte 3 strobed.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (push_req && !push)
            overflow <= 1'b1;
        else if (en_a && io_sel_a && status_sel && we_a[3])
            overflow <= 1'b0;
    end

    assign status_word = {overflow, 15'd0, 16'(io_free_slots)};
`else
    assign status_word = 32'd0;
`endif

    // MMIO read mux: only STATUS returns data, every other offset reads zero.
    // NOTE: default assignment first keeps this combinational block from inferring a latch.
    logic [31:0] io_rdata;
    always_comb begin
        io_rdata = 32'd0;
        if (status_sel)
            io_rdata = status_word;
    end

    // Port A registered read, from MMIO or RAM depending on the decode.
    always_ff @(posedge clk) begin
        if (reset)
            dout_a <= 32'd0;
        else if (en_a)
            dout_a <= io_sel_a ? io_rdata : mem[word_a];
    end

    // Bits that are intentionally ignored (byte offsets, aliased high bits, unused lanes).
    logic unused_bits;
    assign unused_bits = ^{addr_a, addr_b, din_a, io_off, we_a};

endmodule

// File: tb/tb_hubris_mem_responder.sv
// Directed self-checking bench for hubris_mem_responder (default parameters).
module tb_hubris_mem_responder;

    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
`ifdef HUBRIS_MEM_IO_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b, io_out_ready;
    logic [3:0]  we_a, we_b;
    logic [31:0] addr_a, din_a, addr_b, din_b;
    logic [31:0] dout_a, dout_b;
    logic        io_out_valid;
    logic [7:0]  io_out_data;
    logic [4:0]  io_free_slots;

    int vectors = 0;
    int miscompares = 0;

    hubris_mem_responder dut (
        .clk(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b),
        .io_out_valid(io_out_valid), .io_out_data(io_out_data),
        .io_out_ready(io_out_ready), .io_free_slots(io_free_slots)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        en_a = 1'b0; we_a = 4'd0; addr_a = 32'd0; din_a = 32'd0;
        en_b = 1'b0; we_b = 4'd0; din_b = 32'd0;
    endtask

    task automatic wr_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        en_a = 1'b1; we_a = we; addr_a = a; din_a = d;
        tick;
        idle;
    endtask

    task automatic rd_a(input logic [31:0] a, output logic [31:0] d);
        en_a = 1'b1; we_a = 4'd0; addr_a = a;
        tick;
        d = dout_a;
        idle;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_a(IO_BASE, {24'd0, b}, 4'b0001);
    endtask

    task automatic test_reset;
        reset = 1'b1; io_out_ready = 1'b0; addr_b = 32'd0;
        idle;
        tick; tick;
        reset = 1'b0;
        vectors++; if (dout_a !== 32'd0) begin miscompares++; $display("FAIL reset_dout_a: got %h expected 0", dout_a); end
        vectors++; if (dout_b !== 32'd0) begin miscompares++; $display("FAIL reset_dout_b: got %h expected 0", dout_b); end
        vectors++; if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", io_out_valid); end
        vectors++; if (io_free_slots !== 5'd16) begin miscompares++; $display("FAIL reset_free: got %0d expected 16", io_free_slots); end
    endtask

    task automatic test_word_rw;
        logic [31:0] d;
        wr_a(32'h100, 32'hDEAD_BEEF, 4'b1111);
        rd_a(32'h100, d);
        vectors++; if (d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL word_read: got %h expected deadbeef", d); end
        // Read and write of the same word in one access returns the old word.
        en_a = 1'b1; we_a = 4'b1111; addr_a = 32'h100; din_a = 32'h0102_0304;
        tick;
        idle;
        vectors++; if (dout_a !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_first: got %h expected deadbeef", dout_a); end
        rd_a(32'h100, d);
        vectors++; if (d !== 32'h0102_0304) begin miscompares++; $display("FAIL write_visible: got %h expected 01020304", d); end
        rd_a(32'h1100, d);
        vectors++; if (d !== 32'h0102_0304) begin miscompares++; $display("FAIL alias_read: got %h expected 01020304", d); end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] d;
        wr_a(32'h104, 32'h1122_3344, 4'b1111);
        wr_a(32'h104, 32'h00AB_0000, 4'b0100);
        rd_a(32'h104, d);
        vectors++; if (d !== 32'h11AB_3344) begin miscompares++; $display("FAIL byte_strobe: got %h expected 11ab3344", d); end
    endtask

    task automatic test_fetch_hold;
        wr_a(32'h0, 32'hCAFE_F00D, 4'b1111);
        wr_a(32'h8, 32'h5555_5555, 4'b1111);
        en_b = 1'b1; addr_b = 32'h0;
        tick;
        vectors++; if (dout_b !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL fetch0: got %h expected cafef00d", dout_b); end
        en_b = 1'b0; addr_b = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++; if (dout_b !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL fetch_hold%0d: got %h expected cafef00d", i, dout_b); end
        end
        en_b = 1'b1;
        tick;
        vectors++; if (dout_b !== 32'h5555_5555) begin miscompares++; $display("FAIL fetch8: got %h expected 55555555", dout_b); end
        addr_b = IO_BASE;
        tick;
        vectors++; if (dout_b !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL fetch_io_alias: got %h expected cafef00d", dout_b); end
        en_b = 1'b0;
    endtask

    task automatic test_dual_port;
        logic [31:0] d;
        en_a = 1'b1; we_a = 4'b0011; addr_a = 32'h200; din_a = 32'h0000_AAAA;
        en_b = 1'b1; we_b = 4'b1111; addr_b = 32'h200; din_b = 32'hBBBB_BBBB;
        tick;
        idle;
        rd_a(32'h200, d);
        vectors++; if (d !== 32'hBBBB_AAAA) begin miscompares++; $display("FAIL dual_write: got %h expected bbbbaaaa", d); end
        wr_a(32'h300, 32'h1234_5678, 4'b1111);
        en_a = 1'b1; we_a = 4'd0; addr_a = 32'h300;
        en_b = 1'b1; we_b = 4'b1111; addr_b = 32'h300; din_b = 32'h8765_4321;
        tick;
        idle;
        vectors++; if (dout_a !== 32'h1234_5678) begin miscompares++; $display("FAIL cross_a_old: got %h expected 12345678", dout_a); end
        en_a = 1'b1; we_a = 4'b1111; addr_a = 32'h300; din_a = 32'h0BAD_CAFE;
        en_b = 1'b1; we_b = 4'd0; addr_b = 32'h300;
        tick;
        idle;
        vectors++; if (dout_b !== 32'h8765_4321) begin miscompares++; $display("FAIL cross_b_old: got %h expected 87654321", dout_b); end
        rd_a(32'h300, d);
        vectors++; if (d !== 32'h0BAD_CAFE) begin miscompares++; $display("FAIL cross_final: got %h expected 0badcafe", d); end
    endtask

    task automatic test_fifo_basic;
        logic [31:0] d;
        push_byte(8'h48);
        vectors++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h48) begin miscompares++; $display("FAIL push_h: got v=%b d=%h expected v=1 d=48", io_out_valid, io_out_data); end
        vectors++; if (io_free_slots !== 5'd15) begin miscompares++; $display("FAIL free15: got %0d expected 15", io_free_slots); end
        push_byte(8'h69);
        vectors++; if (io_free_slots !== 5'd14 || io_out_data !== 8'h48) begin miscompares++; $display("FAIL push_i: got free=%0d d=%h expected free=14 d=48", io_free_slots, io_out_data); end
        rd_a(IO_BASE, d);
        vectors++; if (d !== 32'd0 || io_free_slots !== 5'd14) begin miscompares++; $display("FAIL tx_read: got %h free=%0d expected 0 free=14", d, io_free_slots); end
        io_out_ready = 1'b1;
        tick;
        vectors++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h69) begin miscompares++; $display("FAIL pop_h: got v=%b d=%h expected v=1 d=69", io_out_valid, io_out_data); end
        tick;
        io_out_ready = 1'b0;
        vectors++; if (io_out_valid !== 1'b0 || io_free_slots !== 5'd16) begin miscompares++; $display("FAIL pop_i: got v=%b free=%0d expected v=0 free=16", io_out_valid, io_free_slots); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic [31:0] exp_status;
        for (int i = 1; i <= 17; i++) push_byte(8'(i));
        vectors++; if (io_free_slots !== 5'd0 || io_out_data !== 8'h01) begin miscompares++; $display("FAIL ovf_full: got free=%0d d=%h expected free=0 d=01", io_free_slots, io_out_data); end
        exp_status = STATUS_EN ? 32'h8000_0000 : 32'd0;
        rd_a(IO_BASE + 32'd4, d);
        vectors++; if (d !== exp_status) begin miscompares++; $display("FAIL ovf_status: got %h expected %h", d, exp_status); end
        wr_a(IO_BASE + 32'd4, 32'd0, 4'b1000);
        rd_a(IO_BASE + 32'd4, d);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL ovf_clear: got %h expected 0", d); end
        wr_a(IO_BASE + 32'd8, 32'hFFFF_FFFF, 4'b1111);
        rd_a(IO_BASE + 32'd8, d);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL io_other: got %h expected 0", d); end
        en_b = 1'b1; addr_b = 32'h8;
        tick;
        en_b = 1'b0;
        vectors++; if (dout_b !== 32'h5555_5555) begin miscompares++; $display("FAIL io_no_ram: got %h expected 55555555", dout_b); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [7:0]  exp;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        en_a = 1'b1; we_a = 4'b0001; addr_a = IO_BASE; din_a = 32'h0000_00EE;
        io_out_ready = 1'b1;
        tick;
        idle;
        io_out_ready = 1'b0;
        vectors++; if (io_free_slots !== 5'd0 || io_out_data !== 8'h02) begin miscompares++; $display("FAIL full_pushpop: got free=%0d d=%h expected free=0 d=02", io_free_slots, io_out_data); end
        rd_a(IO_BASE + 32'd4, d);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL full_no_ovf: got %h expected 0", d); end
        io_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(i + 2) : 8'hEE;
            vectors++; if (io_out_valid !== 1'b1 || io_out_data !== exp) begin miscompares++; $display("FAIL drain%0d: got v=%b d=%h expected v=1 d=%h", i, io_out_valid, io_out_data, exp); end
            tick;
        end
        io_out_ready = 1'b0;
        vectors++; if (io_out_valid !== 1'b0 || io_free_slots !== 5'd16) begin miscompares++; $display("FAIL drain_end: got v=%b free=%0d expected v=0 free=16", io_out_valid, io_free_slots); end
    endtask

    task automatic test_reset_mid_drain;
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        io_out_ready = 1'b1;
        tick;
        vectors++; if (io_out_data !== 8'hA2) begin miscompares++; $display("FAIL mid_pop: got %h expected a2", io_out_data); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        io_out_ready = 1'b0;
        vectors++; if (io_out_valid !== 1'b0 || io_free_slots !== 5'd16) begin miscompares++; $display("FAIL mid_reset: got v=%b free=%0d expected v=0 free=16", io_out_valid, io_free_slots); end
        push_byte(8'h5A);
        vectors++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h5A || io_free_slots !== 5'd15) begin miscompares++; $display("FAIL post_reset_push: got v=%b d=%h free=%0d expected v=1 d=5a free=15", io_out_valid, io_out_data, io_free_slots); end
    endtask

    initial begin
        test_reset;
        test_word_rw;
        test_byte_strobe;
        test_fetch_hold;
        test_dual_port;
        test_fifo_basic;
        test_overflow;
        test_back_to_back;
        test_reset_mid_drain;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
